// File: rtl/vend_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the vending sequencer: coin strobe
//                encoding, coin-to-credit-unit conversion and FSM state type.
//  Options     : none (VEND_SOLD_OUT_EN is consumed by the interface and top)
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Coin strobe encoding as presented by the coin pad logic.
    localparam logic [1:0] c_coin_none    = 2'b00;
    localparam logic [1:0] c_coin_nickel  = 2'b01;
    localparam logic [1:0] c_coin_dime    = 2'b10;
    localparam logic [1:0] c_coin_quarter = 2'b11;

    // Width of a single coin's value in 5-cent units (largest is 5).
    localparam int c_coin_val_w = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    // Credit units contributed by one coin strobe.
    function automatic logic [c_coin_val_w-1:0] coin_value(input logic [1:0] coin);
        logic [c_coin_val_w-1:0] units;
        units = '0;
        case (coin)
            c_coin_nickel:  units = 3'd1;
            c_coin_dime:    units = 3'd2;
            c_coin_quarter: units = 3'd5;
            default:        units = 3'd0;
        endcase
        return units;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vend_sequencer_if
//  Description : Pad-side and dispenser-side signal bundle of the vending
//                sequencer.
//                master : coin, sel_req, cancel, vend_ack (+ sold_out) out;
//                         vend_req, change_out, coin_reject, credit, busy in.
//                slave  : the mirror image, used by vend_sequencer.
//  Options     : VEND_SOLD_OUT_EN adds the sold_out[NUM_SEL] input.
//  Revision    : 1.0  initial release
// ============================================================================
interface vend_sequencer_if #(
    parameter int NUM_SEL  = 3,
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;
    logic [NUM_SEL-1:0]  sel_req;
    logic                cancel;
    logic                vend_ack;
`ifdef VEND_SOLD_OUT_EN
    logic [NUM_SEL-1:0]  sold_out;
`endif
    logic [NUM_SEL-1:0]  vend_req;
    logic                change_out;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

`ifdef VEND_SOLD_OUT_EN
    modport master (
        output coin, sel_req, cancel, vend_ack, sold_out,
        input  vend_req, change_out, coin_reject, credit, busy
    );
    modport slave (
        input  coin, sel_req, cancel, vend_ack, sold_out,
        output vend_req, change_out, coin_reject, credit, busy
    );
`else
    modport master (
        output coin, sel_req, cancel, vend_ack,
        input  vend_req, change_out, coin_reject, credit, busy
    );
    modport slave (
        input  coin, sel_req, cancel, vend_ack,
        output vend_req, change_out, coin_reject, credit, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/vend_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the eligible
//                requests (req_i & mask_i) starting at ptr_i and wrapping
//                modulo N; returns the first hit as one-hot and as an index.
//  Ports       : req_i   [N]      request vector
//                mask_i  [N]      eligibility mask
//                ptr_i   [IDX_W]  search start position (< N)
//                grant_o [N]      one-hot winner, zero when valid_o is low
//                idx_o   [IDX_W]  winner index
//                valid_o          some eligible request exists
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // One extra bit so ptr + offset cannot wrap before the modulo fold.
    localparam logic [IDX_W:0] c_n = (IDX_W + 1)'(N);

    logic [N-1:0]   w_elig;
    logic [IDX_W:0] w_cand;
    logic           w_found;

    assign w_elig = req_i & mask_i;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (w_cand >= c_n) begin
                w_cand = w_cand - c_n;
            end
            if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                grant_o[w_cand[IDX_W-1:0]] = 1'b1;
                idx_o                    = w_cand[IDX_W-1:0];
            end
        end
    end

    assign valid_o = w_found;

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_sequencer
//  Description : Vending controller. Accumulates coin credit, grants one
//                product button round-robin, holds a one-hot dispense request
//                until ack or timeout, then pays change one unit per cycle.
//  Ports       : clock         system clock, rising edge
//                reset         synchronous active-high reset
//                bus (slave)   coin[2], sel_req[NUM_SEL], cancel, vend_ack,
//                              (sold_out[NUM_SEL]) in;
//                              vend_req[NUM_SEL], change_out, coin_reject,
//                              credit[CREDIT_W], busy out (all registered)
//  Options     : VEND_SOLD_OUT_EN - sold-out products are masked from the
//                arbiter; undefined, every button is eligible.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_SEL  = 3,
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic            clock,
    input  logic            reset,
    vend_sequencer_if.slave bus
);

    localparam int c_idx_w   = $clog2(NUM_SEL);
    localparam int c_timer_w = $clog2(TIMEOUT);

    localparam logic [CREDIT_W-1:0]  c_price      = CREDIT_W'(PRICE);
    localparam logic [c_idx_w-1:0]   c_last_idx   = c_idx_w'(NUM_SEL - 1);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    vend_state_t          state_q,       state_d;
    logic [CREDIT_W-1:0]  credit_q,      credit_d;
    logic [c_idx_w-1:0]   ptr_q,         ptr_d;
    logic [c_idx_w-1:0]   winner_q,      winner_d;
    logic [c_timer_w-1:0] timer_q,       timer_d;
    logic [NUM_SEL-1:0]   vend_req_q,    vend_req_d;
    logic                 change_out_q,  change_out_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 busy_q,        busy_d;

    // ------------------------------------------------------------------
    // Coin arithmetic: the carry out of the widened sum is exactly the
    // "credit + value exceeds 2**CREDIT_W-1" condition.
    // ------------------------------------------------------------------
    logic [c_coin_val_w-1:0] w_coin_val;
    logic [CREDIT_W:0]       w_sum;
    logic                    w_coin_nz;
    logic                    w_coin_ovf;

    assign w_coin_val = coin_value(bus.coin);
    assign w_coin_nz  = (bus.coin != c_coin_none);
    assign w_sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(w_coin_val);
    assign w_coin_ovf = w_sum[CREDIT_W];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_SEL-1:0] w_mask;
    logic [NUM_SEL-1:0] w_grant;
    logic [c_idx_w-1:0] w_grant_idx;
    logic               w_grant_valid;
    logic               w_afford;

`ifdef VEND_SOLD_OUT_EN
    assign w_mask = ~bus.sold_out;
`else
    assign w_mask = '1;
`endif

    // Grant eligibility uses the registered credit, not the coin arriving now.
    assign w_afford = (credit_q >= c_price);

    rr_arbiter #(
        .N     (NUM_SEL),
        .IDX_W (c_idx_w)
    ) u_arb (
        .req_i   (bus.sel_req),
        .mask_i  (w_mask),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_grant_idx),
        .valid_o (w_grant_valid)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        timer_d       = timer_q;
        vend_req_d    = vend_req_q;
        coin_reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // credit_q is always zero here, so the sum is the coin value.
                if (w_coin_nz) begin
                    if (w_coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = w_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end
                end
            end

            ST_CREDIT: begin
                if (w_coin_nz) begin
                    if (w_coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = w_sum[CREDIT_W-1:0];
                    end
                end
                if (bus.cancel) begin
                    state_d = ST_CHANGE;
                end else if (w_afford && w_grant_valid) begin
                    vend_req_d = w_grant;
                    winner_d   = w_grant_idx;
                    timer_d    = '0;
                    state_d    = ST_DISPENSE;
                end
            end

            ST_DISPENSE: begin
                coin_reject_d = w_coin_nz;
                timer_d       = timer_q + c_timer_w'(1);
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.vend_ack) begin
                    vend_req_d = '0;
                    timer_d    = '0;
                    credit_d   = credit_q - c_price;
                    ptr_d      = (winner_q == c_last_idx) ? '0
                                                          : winner_q + c_idx_w'(1);
                    state_d    = (credit_q != c_price) ? ST_CHANGE : ST_IDLE;
                end else if (timer_q == c_timer_last) begin
                    vend_req_d = '0;
                    timer_d    = '0;
                    state_d    = ST_CHANGE;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = w_coin_nz;
                if (credit_q != '0) begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs derived from the next state so the pulse train
        // lines up with the CHANGE cycles and is low once back in IDLE.
        change_out_d = (state_d == ST_CHANGE) && (credit_d != '0);
        busy_d       = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            ptr_q         <= '0;
            winner_q      <= '0;
            timer_q       <= '0;
            vend_req_q    <= '0;
            change_out_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            timer_q       <= timer_d;
            vend_req_q    <= vend_req_d;
            change_out_q  <= change_out_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.vend_req    = vend_req_q;
    assign bus.change_out  = change_out_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_sequencer
//  Description : Self-checking bench for vend_sequencer. A session driver
//                issues coins / selections / acks and queues the events the
//                customer should observe; a monitor pops and compares them.
//  Options     : VEND_SOLD_OUT_EN drives sold_out and adds sold-out sessions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_sequencer;

    localparam int NUM_SEL  = 3;
    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;
    localparam int TIMEOUT  = 16;
    localparam int MAXC     = (1 << CREDIT_W) - 1;

    localparam int EV_REJECT = 0;
    localparam int EV_GRANT  = 1;
    localparam int EV_HOLD   = 2;
    localparam int EV_DONE   = 3;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vend_sequencer_if #(.NUM_SEL(NUM_SEL), .CREDIT_W(CREDIT_W)) bus ();

    vend_sequencer #(
        .NUM_SEL  (NUM_SEL),
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    ev_t                exp_q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    bit                 mon_en  = 1'b0;
    int                 ptr_m   = 0;
    logic [NUM_SEL-1:0] soldout_m = '0;
    logic [1:0]         coins[8];
    int                 ncoins  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Credit units of a coin code, straight from the price list.
    function automatic int cval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b10) return 2;
        if (c == 2'b11) return 5;
        return 0;
    endfunction

    // Customer-level rule: first requested, in-stock button at or after ptr.
    function automatic int pick(input logic [NUM_SEL-1:0] e, input int p);
        for (int k = 0; k < NUM_SEL; k++) begin
            if (e[(p + k) % NUM_SEL]) return (p + k) % NUM_SEL;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    ev_t m_ev;
    bit  m_ok;
    int  prev_vreq = 0;
    bit  prev_busy = 1'b0;
    int  hold_cnt  = 0;
    int  pulse_cnt = 0;

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        e  = '{-1, 0, 0};
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind);
            if (!ok) check("event_order_kind", kind, e.kind);
        end
    endtask

    always @(negedge clock) begin
        if (reset || !mon_en) begin
            prev_vreq = 0;
            prev_busy = 1'b0;
            hold_cnt  = 0;
            pulse_cnt = 0;
        end else begin
            if (bus.coin_reject) begin
                pop_ev(EV_REJECT, m_ev, m_ok);
                if (m_ok) check("reject_credit", int'(bus.credit), m_ev.a);
            end
            if (bus.vend_req != '0 && prev_vreq == 0) begin
                pop_ev(EV_GRANT, m_ev, m_ok);
                if (m_ok) begin
                    check("grant_vend_req", int'(bus.vend_req), m_ev.a);
                    check("grant_credit", int'(bus.credit), m_ev.b);
                end
            end
            if (bus.vend_req != '0) begin
                hold_cnt++;
            end else if (prev_vreq != 0) begin
                pop_ev(EV_HOLD, m_ev, m_ok);
                if (m_ok) check("vend_req_hold_cycles", hold_cnt, m_ev.a);
                hold_cnt = 0;
            end
            if (bus.change_out) begin
                pulse_cnt++;
                check("change_out_busy", int'(bus.busy), 1);
            end
            if (!bus.busy && prev_busy) begin
                pop_ev(EV_DONE, m_ev, m_ok);
                if (m_ok) check("change_pulses", pulse_cnt, m_ev.a);
                pulse_cnt = 0;
            end
            prev_vreq = int'(bus.vend_req);
            prev_busy = bus.busy;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive_idle();
        bus.coin     = 2'b00;
        bus.sel_req  = '0;
        bus.cancel   = 1'b0;
        bus.vend_ack = 1'b0;
`ifdef VEND_SOLD_OUT_EN
        bus.sold_out = soldout_m;
`endif
    endtask

    task automatic do_reset(input bit check_outputs);
        mon_en = 1'b0;
        drive_idle();
        reset = 1'b1;
        @(negedge clock);
        if (check_outputs) begin
            check("reset_vend_req",    int'(bus.vend_req),    0);
            check("reset_change_out",  int'(bus.change_out),  0);
            check("reset_coin_reject", int'(bus.coin_reject), 0);
            check("reset_credit",      int'(bus.credit),      0);
            check("reset_busy",        int'(bus.busy),        0);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        @(negedge clock);
        mon_en = 1'b1;
    endtask

    task automatic push(input int kind, input int a, input int b);
        exp_q.push_back('{kind, a, b});
    endtask

    // mode: 0 cancel (sel_req asserted alongside), 1 vend with ack after d
    // further cycles, 2 vend left to time out.
    task automatic session(input logic [NUM_SEL-1:0] sel, input int mode_in,
                           input int d, input bit coin_grant, input bit coin_disp);
        int         credit_m;
        int         v;
        int         win;
        int         mode;
        int         k;
        logic [1:0] c;
        credit_m = 0;
        mode     = mode_in;
        drive_idle();

        for (int i = 0; i < ncoins; i++) begin
            v        = cval(coins[i]);
            bus.coin = coins[i];
            if (credit_m + v > MAXC) push(EV_REJECT, credit_m, 0);
            else                     credit_m += v;
            @(negedge clock);
            bus.coin = 2'b00;
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end

        win = pick(sel & ~soldout_m, ptr_m);
        if (mode != 0 && (credit_m < PRICE || win < 0)) begin
            // The press must not produce a grant; the customer then cancels.
            bus.sel_req = sel;
            @(negedge clock);
            bus.sel_req = '0;
            @(negedge clock);
            mode = 0;
        end

        if (mode == 0) begin
            push(EV_DONE, credit_m, 0);
            bus.cancel  = 1'b1;
            bus.sel_req = sel;
            @(negedge clock);
            bus.cancel  = 1'b0;
            bus.sel_req = '0;
        end else begin
            bus.sel_req = sel;
            if (coin_grant) begin
                c        = 2'($urandom_range(1, 3));
                v        = cval(c);
                bus.coin = c;
                if (credit_m + v > MAXC) push(EV_REJECT, credit_m, 0);
                else                     credit_m += v;
            end
            push(EV_GRANT, 1 << win, credit_m);
            @(negedge clock);
            bus.sel_req = '0;
            bus.coin    = 2'b00;
            if (coin_disp && (mode == 2 || d > 0)) begin
                bus.coin = 2'($urandom_range(1, 3));
                push(EV_REJECT, credit_m, 0);
            end
            if (mode == 1) begin
                push(EV_HOLD, d + 1, 0);
                push(EV_DONE, credit_m - PRICE, 0);
                for (int i = 0; i < d; i++) begin
                    @(negedge clock);
                    bus.coin = 2'b00;
                end
                bus.vend_ack = 1'b1;
                @(negedge clock);
                bus.vend_ack = 1'b0;
                bus.coin     = 2'b00;
                ptr_m        = (win + 1) % NUM_SEL;
            end else begin
                push(EV_HOLD, TIMEOUT, 0);
                push(EV_DONE, credit_m, 0);
                @(negedge clock);
                bus.coin = 2'b00;
            end
        end

        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (k >= 100) check("busy_drop_timeout", k, 0);
        @(negedge clock);
        check("end_credit",   int'(bus.credit),   0);
        check("end_vend_req", int'(bus.vend_req), 0);
        check("events_left",  exp_q.size(),       0);
        if (exp_q.size() != 0 || bus.credit != '0 || bus.busy) do_reset(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        do_reset(1'b1);

        // Dime + nickel, select 001, ack: exact price, no change.
        coins[0] = 2'b10; coins[1] = 2'b01; ncoins = 2;
        session(3'b001, 1, 2, 1'b0, 1'b0);

        // Quarter, select 010, immediate ack: two units of change.
        coins[0] = 2'b11; ncoins = 1;
        session(3'b010, 1, 0, 1'b0, 1'b0);

        // Round-robin from a fresh pointer: 001 then 010.
        do_reset(1'b0);
        coins[0] = 2'b11; ncoins = 1;
        session(3'b111, 1, 1, 1'b0, 1'b0);
        session(3'b111, 1, 1, 1'b0, 1'b0);

        // Timeout with a coin during dispense; pointer stays, so 100 twice.
        coins[0] = 2'b10; coins[1] = 2'b10; ncoins = 2;
        session(3'b111, 2, 0, 1'b0, 1'b1);
        coins[0] = 2'b11; ncoins = 1;
        session(3'b111, 1, 3, 1'b0, 1'b0);

        // Credit 12, quarter rejected; coin in dispense rejected.
        coins[0] = 2'b11; coins[1] = 2'b11; coins[2] = 2'b10; coins[3] = 2'b11;
        ncoins = 4;
        session(3'b001, 1, 3, 1'b0, 1'b1);

        // Cancel beats a simultaneous selection.
        coins[0] = 2'b10; coins[1] = 2'b01; ncoins = 2;
        session(3'b111, 0, 0, 1'b0, 1'b0);

        // Ack on the last cycle before timeout still wins.
        coins[0] = 2'b11; ncoins = 1;
        session(3'b111, 1, TIMEOUT - 1, 1'b0, 1'b0);

        // Insufficient credit: selection ignored.
        coins[0] = 2'b01; ncoins = 1;
        session(3'b001, 1, 0, 1'b0, 1'b0);

`ifdef VEND_SOLD_OUT_EN
        soldout_m = 3'b001;
        coins[0] = 2'b11; ncoins = 1;
        session(3'b001, 1, 0, 1'b0, 1'b0);
        session(3'b011, 1, 0, 1'b0, 1'b0);
        soldout_m = '0;
`endif

        // Reset in the middle of a dispense.
        mon_en = 1'b0;
        bus.coin = 2'b11;
        @(negedge clock);
        bus.coin = 2'b00;
        @(negedge clock);
        bus.sel_req = 3'b100;
        @(negedge clock);
        bus.sel_req = '0;
        check("pre_reset_vend_req", int'(bus.vend_req), 4);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_vend_req", int'(bus.vend_req), 0);
        check("mid_reset_credit",   int'(bus.credit),   0);
        check("mid_reset_busy",     int'(bus.busy),     0);
        do_reset(1'b0);

        // Randomised sessions.
        for (int s = 0; s < 40; s++) begin
            ncoins = $urandom_range(1, 6);
            for (int i = 0; i < ncoins; i++) coins[i] = 2'($urandom_range(1, 3));
`ifdef VEND_SOLD_OUT_EN
            soldout_m = NUM_SEL'($urandom_range(0, 3));
`endif
            session(NUM_SEL'($urandom_range(1, (1 << NUM_SEL) - 1)),
                    $urandom_range(0, 2), $urandom_range(0, TIMEOUT - 1),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
